// File: rtl/conv_sched_if.sv
// conv_sched_if -- output stream of the 3x3 convolution scheduler.
//   out_valid : result word valid (driven by the scheduler)
//   out_ready : sink ready; a word transfers when out_valid && out_ready
//   out_addr  : output memory address of the current result
//   out_data  : result word
// master modport is the scheduler side, slave modport is the sink side.
interface conv_sched_if #(
    parameter int NBITS  = 20,
    parameter int ADDR_W = 16
);
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [NBITS-1:0]  out_data;

    modport master (output out_valid, output out_addr, output out_data, input out_ready);
    modport slave  (input out_valid, input out_addr, input out_data, output out_ready);
endinterface

// File: rtl/conv_sched.sv
// conv_sched -- address/control scheduler for a valid-region 3x3 convolution.
// For every output window it fetches the 9 input pixels (row-major), steers an
// external MAC (mac_clr/mac_en/k_idx), then writes the accumulated result.
//   clock, reset      : single clock, synchronous active-low reset
//   start, img_w/h,
//   base_in/out       : job request and configuration (latched on accept)
//   mem_ren/mem_addr  : input memory read port, data returns 1 cycle later
//   mac_clr/en, k_idx : external MAC control, mac_result returned
//   ob                : output stream (conv_sched_if master)
//   busy, done, err   : status
module conv_sched #(
    parameter int NBITS  = 20,
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DIM_W-1:0]  img_w,
    input  logic [DIM_W-1:0]  img_h,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [ADDR_W-1:0] base_out,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic [3:0]        k_idx,
    input  logic [NBITS-1:0]  mac_result,
    conv_sched_if.master      ob,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_DONE} state_t;

    state_t            state, state_nx;
    logic [DIM_W-1:0]  w, h, r, c;
    logic [3:0]        k;
    logic [1:0]        kc;        // k % 3
    logic [ADDR_W-1:0] row_off;   // (k / 3) * img_w
    logic [ADDR_W-1:0] win_base;  // base_in + r*img_w + c
    logic [ADDR_W-1:0] out_ptr;   // base_out + r*(img_w-2) + c
    logic [NBITS-1:0]  data_hold;
    logic              wr_first;
    logic              cfg_ok, last_col, last_win, xfer;

    assign cfg_ok   = (img_w >= DIM_W'(3)) && (img_h >= DIM_W'(3));
    assign last_col = (c == w - DIM_W'(3));
    assign last_win = last_col && (r == h - DIM_W'(3));
    assign xfer     = (state == S_WRITE) && ob.out_ready;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = cfg_ok ? S_FETCH : S_DONE;
            S_FETCH: if (k == 4'd8) state_nx = S_DRAIN;
            S_DRAIN: state_nx = S_WRITE;
            S_WRITE: if (xfer) state_nx = last_win ? S_DONE : S_FETCH;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign mem_ren      = (state == S_FETCH);
    assign mem_addr     = mem_ren ? (win_base + row_off + ADDR_W'(kc)) : '0;
    assign mac_clr      = mac_en && (k_idx == 4'd0);
    assign ob.out_valid = (state == S_WRITE);
    assign ob.out_addr  = ob.out_valid ? out_ptr : '0;
    // mac_result is only valid from the first WRITE cycle, so that cycle
    // forwards it directly and later stall cycles replay the captured copy.
    assign ob.out_data  = wr_first ? mac_result : data_hold;
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_IDLE;
            w         <= '0;
            h         <= '0;
            r         <= '0;
            c         <= '0;
            k         <= '0;
            kc        <= '0;
            row_off   <= '0;
            win_base  <= '0;
            out_ptr   <= '0;
            data_hold <= '0;
            wr_first  <= 1'b0;
            mac_en    <= 1'b0;
            k_idx     <= '0;
            err       <= 1'b0;
        end else begin
            state    <= state_nx;
            mac_en   <= mem_ren;
            k_idx    <= mem_ren ? k : 4'd0;
            wr_first <= (state == S_DRAIN);
            if (wr_first) data_hold <= mac_result;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            w        <= img_w;
                            h        <= img_h;
                            win_base <= base_in;
                            out_ptr  <= base_out;
                            r        <= '0;
                            c        <= '0;
                            k        <= '0;
                            kc       <= '0;
                            row_off  <= '0;
                            err      <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (k == 4'd8) begin
                        k       <= '0;
                        kc      <= '0;
                        row_off <= '0;
                    end else begin
                        k <= k + 4'd1;
                        if (kc == 2'd2) begin
                            kc      <= '0;
                            row_off <= row_off + ADDR_W'(w);
                        end else begin
                            kc <= kc + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (xfer) begin
                        out_ptr <= out_ptr + ADDR_W'(1);
                        // Wrapping from column img_w-3 to column 0 of the next
                        // row moves the window origin by exactly 3 pixels.
                        if (last_col) begin
                            c        <= '0;
                            r        <= r + DIM_W'(1);
                            win_base <= win_base + ADDR_W'(3);
                        end else begin
                            c        <= c + DIM_W'(1);
                            win_base <= win_base + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched -- randomized self-checking bench for conv_sched.
// The bench models the input memory and the external MAC, precomputes every
// expected read address and result word from the window arithmetic, and
// checks the DUT against those queues on every negedge.
module tb_conv_sched;
    localparam int NB = 20;
    localparam int AW = 16;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] img_w = '0, img_h = '0;
    logic [AW-1:0] base_in = '0, base_out = '0;
    logic          mem_ren, mac_clr, mac_en, busy, done, err;
    logic [AW-1:0] mem_addr;
    logic [3:0]    k_idx;
    logic [NB-1:0] mac_result;

    conv_sched_if #(.NBITS(NB), .ADDR_W(AW)) ob ();

    conv_sched #(.NBITS(NB), .ADDR_W(AW), .DIM_W(DW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .img_w(img_w), .img_h(img_h), .base_in(base_in), .base_out(base_out),
        .mem_ren(mem_ren), .mem_addr(mem_addr),
        .mac_clr(mac_clr), .mac_en(mac_en), .k_idx(k_idx), .mac_result(mac_result),
        .ob(ob), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] pix(input logic [AW-1:0] a);
        return NB'((int'(a) * 37 + 11) % 251);
    endfunction

    function automatic logic [AW-1:0] addr_of(input int bi, input int w, input int r,
                                              input int c, input int k);
        return AW'(bi + (r + k / 3) * w + c + k % 3);
    endfunction

    // Environment: input memory with 1-cycle read latency and a 3x3 MAC
    // using weight k+1 for index k.
    logic [NB-1:0] rdata = '0, acc = '0;
    assign mac_result = acc;
    always @(posedge clock) begin
        if (mem_ren) rdata <= pix(mem_addr);
        if (mac_en) acc <= (mac_clr ? '0 : acc) + NB'(32'(rdata) * (32'(k_idx) + 1));
    end

    // Output sink: random readiness, or forced stall for blk valid cycles.
    int ready_pct = 100, blk = 0;
    always @(posedge clock) begin
        #1;
        if (blk > 0) begin
            ob.out_ready = 1'b0;
            if (ob.out_valid) blk--;
        end else begin
            ob.out_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Reference model: expected reads and results of a whole job.
    logic [AW-1:0] exp_addr[$], exp_oaddr[$], obs_maddr[$], obs_oaddr[$];
    logic [NB-1:0] exp_odata[$];

    task automatic plan(input int w, input int h, input int bi, input int bo);
        exp_addr.delete(); exp_oaddr.delete(); exp_odata.delete();
        if (w < 3 || h < 3) return;
        for (int r = 0; r < h - 2; r++)
            for (int c = 0; c < w - 2; c++) begin
                int sum;
                sum = 0;
                for (int k = 0; k < 9; k++) begin
                    exp_addr.push_back(addr_of(bi, w, r, c, k));
                    sum += int'(pix(addr_of(bi, w, r, c, k))) * (k + 1);
                end
                exp_oaddr.push_back(AW'(bo + r * (w - 2) + c));
                exp_odata.push_back(NB'(sum));
            end
    endtask

    // Compare process.
    int nclr = 0, nstall = 0, ndone = 0, nvalid = 0, done_cyc = -1;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [NB-1:0] prev_data = '0;
    always @(negedge clock) begin
        if (reset) begin
            if (mem_ren) begin
                obs_maddr.push_back(mem_addr);
                chk("mem_read_planned", 64'(exp_addr.size() != 0), 64'd1);
                if (exp_addr.size() != 0) chk("mem_addr", 64'(mem_addr), 64'(exp_addr.pop_front()));
            end
            if (mac_clr) begin
                nclr++;
                chk("mac_clr_at_k0", 64'({mac_en, k_idx}), 64'd16);
            end
            if (ob.out_valid) begin
                nvalid++;
                chk("no_fetch_in_write", 64'(mem_ren), 64'd0);
                if (prev_stall)
                    chk("out_hold", 64'({ob.out_addr, ob.out_data}), 64'({prev_addr, prev_data}));
                if (ob.out_ready) begin
                    obs_oaddr.push_back(ob.out_addr);
                    chk("out_planned", 64'(exp_oaddr.size() != 0), 64'd1);
                    if (exp_oaddr.size() != 0) begin
                        chk("out_addr", 64'(ob.out_addr), 64'(exp_oaddr.pop_front()));
                        chk("out_data", 64'(ob.out_data), 64'(exp_odata.pop_front()));
                    end
                end else begin
                    nstall++;
                end
                prev_stall = !ob.out_ready;
                prev_addr  = ob.out_addr;
                prev_data  = ob.out_data;
            end else begin
                prev_stall = 1'b0;
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic chk_zero(input string tag);
        chk(tag, 64'({mem_ren, mem_addr, mac_en, mac_clr, k_idx, ob.out_valid, ob.out_addr,
                      ob.out_data, busy, done, err}), 64'd0);
    endtask

    // One job: start (optionally held), wait for done, check the aftermath.
    // exp_lat is done cycle minus the cycle start was first high (-1: unchecked).
    task automatic run_job(input int w, input int h, input int bi, input int bo,
                           input bit hold, input int exp_lat, input string tag);
        int n, c0;
        bit bad;
        bad = (w < 3) || (h < 3);
        n   = bad ? 0 : (w - 2) * (h - 2);
        plan(w, h, bi, bo);
        nclr = 0; nstall = 0; ndone = 0; nvalid = 0; done_cyc = -1;
        obs_maddr.delete(); obs_oaddr.delete();
        @(posedge clock); #1;
        img_w = DW'(w); img_h = DW'(h); base_in = AW'(bi); base_out = AW'(bo);
        start = 1'b1;
        c0 = cyc;
        @(posedge clock); #1;
        // Scramble the configuration: only the latched copy may be used.
        img_w = DW'($urandom_range(0, 255)); img_h = DW'($urandom_range(0, 255));
        base_in = AW'($urandom); base_out = AW'($urandom);
        if (!hold) start = 1'b0;
        for (int i = 0; i < 4000 && ndone == 0; i++) begin
            @(negedge clock); #1;
        end
        start = 1'b0;
        chk({tag, "_done"}, 64'(ndone), 64'd1);
        if (exp_lat >= 0) chk({tag, "_latency"}, 64'(done_cyc - c0), 64'(exp_lat));
        chk({tag, "_err"}, 64'(err), 64'(bad));
        repeat (3) @(negedge clock);
        #1;
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        chk({tag, "_single_done"}, 64'(ndone), 64'd1);
        chk({tag, "_reads_left"}, 64'(exp_addr.size()), 64'd0);
        chk({tag, "_outs_left"}, 64'(exp_oaddr.size()), 64'd0);
        chk({tag, "_out_count"}, 64'(obs_oaddr.size()), 64'(n));
        chk({tag, "_clr_count"}, 64'(nclr), 64'(n));
    endtask

    logic [AW-1:0] lit_a[9] = '{16'h100, 16'h101, 16'h102, 16'h105, 16'h106,
                                16'h107, 16'h10A, 16'h10B, 16'h10C};

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_zero("reset_state");
        @(posedge clock); #1;
        reset = 1'b1;

        // Pin the model's address arithmetic with hand-computed values.
        for (int k = 0; k < 9; k++) chk("model_addr", 64'(addr_of(16'h100, 5, 0, 0, k)), 64'(lit_a[k]));
        chk("model_wrap_k2", 64'(addr_of(16'hFFFE, 4, 0, 0, 2)), 64'd0);
        chk("model_out_last", 64'(AW'(16'h200 + 2 * 3 + 2)), 64'h208);

        // 5x5 job, sink always ready: 9 outputs x 11 cycles, done one cycle later.
        ready_pct = 100;
        run_job(5, 5, 16'h100, 16'h200, 1'b0, 100, "job5x5");
        chk("job5x5_nreads", 64'(obs_maddr.size()), 64'd81);
        for (int i = 0; i < 9 && i < obs_maddr.size(); i++) chk("job5x5_first_reads", 64'(obs_maddr[i]), 64'(lit_a[i]));
        for (int i = 0; i < obs_oaddr.size(); i++) chk("job5x5_out_addr", 64'(obs_oaddr[i]), 64'(16'h200 + i));

        // Same job, first output stalled for 5 cycles.
        blk = 5;
        run_job(5, 5, 16'h100, 16'h200, 1'b0, 105, "stall");
        chk("stall_cycles", 64'(nstall), 64'd5);

        // Rejected start: err, done next cycle, no reads.
        run_job(2, 8, 16'h100, 16'h200, 1'b0, 1, "reject");
        chk("reject_no_reads", 64'(obs_maddr.size()), 64'd0);
        chk("reject_err_holds", 64'(err), 64'd1);

        // Reset from IDLE clears err.
        @(posedge clock); #1; reset = 1'b0;
        @(posedge clock); #1; reset = 1'b1;
        @(negedge clock);
        chk_zero("reset_idle");

        // Reset while FETCH is at k=4.
        plan(5, 5, 16'h100, 16'h200);
        @(posedge clock); #1;
        img_w = 8'd5; img_h = 8'd5; base_in = 16'h100; base_out = 16'h200; start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock); #1;
        chk("fetch_k4_addr", 64'(mem_addr), 64'h106);
        reset = 1'b0;
        @(posedge clock); #1; reset = 1'b1;
        @(negedge clock);
        chk_zero("reset_mid_fetch");
        exp_addr.delete(); exp_oaddr.delete(); exp_odata.delete();
        nvalid = 0; ndone = 0;
        repeat (30) @(negedge clock);
        chk("abandoned_job_silent", 64'(nvalid + ndone), 64'd0);
        ready_pct = 60;
        run_job(5, 5, 16'h100, 16'h200, 1'b0, -1, "after_reset");

        // Address wrap-around at the top of the address space.
        ready_pct = 100;
        run_job(4, 3, 16'hFFFE, 16'h0010, 1'b0, 23, "wrap");
        if (obs_maddr.size() > 2) chk("wrap_k2_addr", 64'(obs_maddr[2]), 64'd0);
        else chk("wrap_nreads", 64'(obs_maddr.size()), 64'd18);

        // start held high through the job and its DONE cycle.
        ready_pct = 70;
        run_job(6, 4, 16'h3000, 16'h4000, 1'b1, -1, "held");

        // Random jobs, including some rejected configurations.
        for (int j = 0; j < 6; j++) begin
            ready_pct = $urandom_range(30, 100);
            run_job($urandom_range(1, 9), $urandom_range(2, 8), $urandom_range(0, 65535),
                    $urandom_range(0, 65535), 1'($urandom_range(0, 1)), -1, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 Parameter NBITS, default 20, data width of pixel and result words (regC).
REQ-002 Parameter ADDR_W, default 16, memory address width.
REQ-003 Parameter DIM_W, default 8, width of image dimension inputs.
REQ-004 Port clock  input  1  single clock; all state on rising edge.
REQ-005 Port reset  input  1  synchronous, active-low reset.
REQ-006 Port start  input  1  start request, sampled only in IDLE.
REQ-007 Port img_w  input  DIM_W  image width in pixels, latched at accepted start.
REQ-008 Port img_h  input  DIM_W  image height in pixels, latched at accepted start.
REQ-009 Port base_in  input  ADDR_W  input image base address, latched at accepted start.
REQ-010 Port base_out  input  ADDR_W  output image base address, latched at accepted start.
REQ-011 Port mem_ren  output  1  input-memory read enable; read data returns exactly 1 cycle later.
REQ-012 Port mem_addr  output  ADDR_W  input-memory read address.
REQ-013 Port mac_clr  output  1  clears the external 3x3 MAC accumulator, coincident with the k=0 product.
REQ-014 Port mac_en  output  1  external MAC consumes the pixel returned by memory this cycle.
REQ-015 Port k_idx  output  4  weight index 0..8 (row-major param9 index) for the current mac_en.
REQ-016 Port mac_result  input  NBITS  accumulated result, valid from the cycle after the k=8 mac_en.
REQ-017 Port out_valid  output  1  output word valid.
REQ-018 Port out_ready  input  1  output sink ready; transfer when out_valid and out_ready are both 1.
REQ-019 Port out_addr  output  ADDR_W  output address of the current result.
REQ-020 Port out_data  output  NBITS  result word (mac_result captured).
REQ-021 Port busy  output  1  high in every state except IDLE.
REQ-022 Port done  output  1  one-cycle pulse at end of a job.
REQ-023 Port err  output  1  set when a start is rejected; cleared on next accepted start or reset.

Function
REQ-024 States: IDLE, FETCH, DRAIN, WRITE, DONE.
REQ-025 IDLE: start=1 with img_w>=3 and img_h>=3 latches configuration, sets r=c=k=0, err=0, goes to FETCH.
REQ-026 IDLE: start=1 with img_w<3 or img_h<3 sets err=1, goes to DONE with no memory access.
REQ-027 start is ignored in every state other than IDLE.
REQ-028 FETCH: mem_ren=1 each cycle, mem_addr = base_in + (r+k/3)*img_w + (c+k%3), all arithmetic modulo 2^ADDR_W; k increments 0..8; after k=8 go to DRAIN (exactly 9 FETCH cycles).
REQ-029 mac_en and k_idx are the 1-cycle-delayed mem_ren and k; mac_clr = mac_en and delayed k==0.
REQ-030 DRAIN: one cycle, mem_ren=0, mac_en=1 with k_idx=8, then WRITE.
REQ-031 WRITE: first cycle captures mac_result into out_data; out_valid=1 from that cycle on; out_addr = base_out + r*(img_w-2) + c; out_data/out_addr stable while out_valid=1 and out_ready=0.
REQ-032 WRITE handshake: if c = img_w-3 then c=0, r=r+1, else c=c+1; if the transferred word was r=img_h-3, c=img_w-3 go to DONE, else FETCH with k=0.
REQ-033 Minimum per-output cost 11 cycles (9 FETCH + 1 DRAIN + 1 WRITE with out_ready=1); output count (img_w-2)*(img_h-2), raster order.
REQ-034 DONE: done=1 for one cycle, busy=1, then IDLE; err holds.
REQ-035 mem_ren, mac_en, mac_clr, out_valid are 0 in IDLE, DONE and outside their stated states.

Reset
REQ-036 reset=0 at a rising edge forces IDLE, r=c=k=0, all outputs 0 (including err, out_data, out_addr, mem_addr) on the following cycle, regardless of current state.
REQ-037 Reset asserted mid-job abandons the job; no out_valid or done follows until a new start.

Verification
REQ-038 Reset mid-FETCH (k=4) -> next cycle all outputs 0, state IDLE; later start runs full job normally.
REQ-039 img_w=5, img_h=5, base_in=0x100, base_out=0x200, out_ready=1 -> 9 outputs at out_addr 0x200..0x208, first FETCH addresses 0x100,0x101,0x102,0x105,0x106,0x107,0x10A,0x10B,0x10C; done pulses 99 cycles after start +1 (IDLE->DONE path).
REQ-040 Same job with out_ready=0 for 5 cycles on output 0 -> out_valid, out_addr=0x200, out_data held 5 cycles; no FETCH until handshake.
REQ-041 start with img_w=2, img_h=8 -> err=1, done pulse next cycle, mem_ren never asserted.
REQ-042 img_w=4, img_h=3, base_in=0xFFFE -> 2 outputs; addresses wrap (k=2 of first window = 0x0000).
REQ-043 start held high during a job and at DONE -> not re-latched until IDLE; mac_clr exactly once per output, coincident with k_idx=0.
